vector_mem_sequencer: RTL and testbench

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

---
 rtl/vector_mem_sequencer.sv | 155 +++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: stalls decode and injects per-element load/store beats for vector memory ops.
// Optional watchdog abort on a stuck memory port is enabled by defining VSEQ_TIMEOUT_EN.
`default_nettype none

module vector_mem_sequencer #(
  parameter int VLEN    = 4,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       instruction_type_i,
  input  logic [4:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             stall_o,
  output logic             inj_valid_o,
  output logic [1:0]       inj_type_o,
  output logic [4:0]       inj_opcode_o,
  output logic [IDX_W-1:0] elem_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [4:0]       OP_LOAD   = 5'b00110;
  localparam logic [4:0]       OP_STORE  = 5'b00111;
  localparam logic [4:0]       OP_BUBBLE = 5'b00101;
  localparam logic [1:0]       TYPE_INJ  = 2'b01;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VLEN - 1);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vec_hit;
  logic             timeout_hit;

  assign vec_hit = (instruction_type_i == 2'b00) && opcode_i[4];

`ifdef VSEQ_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic             unused_ok;

  // Counts consecutive not-ready cycles of the active burst; fires on the TIMEOUT-th one.
  assign timeout_hit = (state_q != S_IDLE) && !mem_ready_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = '0;
    error_d = error_q | timeout_hit;
    if ((state_q != S_IDLE) && !mem_ready_i && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign error_o   = error_q;
  assign unused_ok = &{1'b0, opcode_i[2:0]};
`else
  logic unused_ok;

  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
  assign unused_ok   = &{1'b0, opcode_i[2:0], TIMEOUT[0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    idx_d        = idx_q;
    stall_o      = 1'b0;
    inj_valid_o  = 1'b0;
    inj_type_o   = 2'b00;
    inj_opcode_o = 5'b00000;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        // The instruction sitting in decode performs beat 0 itself.
        if (vec_hit) begin
          stall_o = 1'b1;
          dir_d   = opcode_i[3];
          idx_d   = IDX_W'(1);
          state_d = S_BURST;
        end
      end

      S_BURST, S_HOLD: begin
        stall_o    = 1'b1;
        inj_type_o = TYPE_INJ;
        if (mem_ready_i) begin
          inj_valid_o  = 1'b1;
          inj_opcode_o = dir_q ? OP_STORE : OP_LOAD;
          if (idx_q == LAST_IDX) begin
            done_o  = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_BURST;
          end
        end else begin
          inj_opcode_o = OP_BUBBLE;
          if (timeout_hit) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign elem_idx_o = idx_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: table vectors, corner sequences and random traffic against a beat-level model.
`default_nettype none

module tb_vector_mem_sequencer;

  localparam int VLEN    = 4;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 16;
`ifdef VSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       itype;
  logic [4:0]       op;
  logic             ready;
  logic             stall, inj_valid, busy, done, error;
  logic [1:0]       inj_type;
  logic [4:0]       inj_opcode;
  logic [IDX_W-1:0] elem_idx;

  always #5 clk = ~clk;

  vector_mem_sequencer #(.VLEN(VLEN), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .instruction_type_i(itype), .opcode_i(op), .mem_ready_i(ready),
    .stall_o(stall), .inj_valid_o(inj_valid), .inj_type_o(inj_type),
    .inj_opcode_o(inj_opcode), .elem_idx_o(elem_idx), .busy_o(busy),
    .done_o(done), .error_o(error)
  );

  typedef logic [15:0] obs_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t last_obs;

  // Beat-level reference: whether a burst is active, which element is next, direction, watchdog.
  bit m_active = 0;
  int m_idx    = 0;
  bit m_dir    = 0;
  bit m_err    = 0;
  int m_stalls = 0;

  function automatic obs_t pack(input logic s, input logic v, input logic [1:0] t,
                                input logic [4:0] o, input logic [3:0] i,
                                input logic b, input logic d, input logic e);
    return {s, v, t, o, i, b, d, e};
  endfunction

  function automatic obs_t dut_obs();
    return pack(stall, inj_valid, inj_type, inj_opcode, elem_idx, busy, done, error);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = dut_obs();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (stall,valid,type,op,idx,busy,done,err)",
                  name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  function automatic obs_t model_out(input logic [1:0] t, input logic [4:0] o, input logic rd);
    logic [3:0] ix;
    ix = m_idx[3:0];
    if (!m_active)
      return pack((t == 2'b00) && o[4], 1'b0, 2'b00, 5'd0, 4'd0, 1'b0, 1'b0, m_err);
    if (rd)
      return pack(1'b1, 1'b1, 2'b01, m_dir ? 5'd7 : 5'd6, ix, 1'b1,
                  m_idx == VLEN - 1, m_err);
    return pack(1'b1, 1'b0, 2'b01, 5'd5, ix, 1'b1, 1'b0, m_err);
  endfunction

  task automatic model_update(input logic r, input logic [1:0] t, input logic [4:0] o,
                              input logic rd);
    if (r) begin
      m_active = 0; m_idx = 0; m_dir = 0; m_err = 0; m_stalls = 0;
    end else if (!m_active) begin
      if (t == 2'b00 && o[4]) begin
        m_active = 1; m_idx = 1; m_dir = o[3]; m_stalls = 0;
      end
    end else if (rd) begin
      m_stalls = 0;
      if (m_idx == VLEN - 1) begin
        m_active = 0; m_idx = 0;
      end else begin
        m_idx++;
      end
    end else begin
      m_stalls++;
      if (TO_EN && m_stalls == TIMEOUT) begin
        m_active = 0; m_idx = 0; m_err = 1; m_stalls = 0;
      end
    end
  endtask

  // One clock: drive, compare against the model mid-cycle (skipped while in reset), advance.
  task automatic step(input string name, input logic r, input logic [1:0] t,
                      input logic [4:0] o, input logic rd);
    rst = r; itype = t; op = o; ready = rd;
    @(negedge clk);
    last_obs = dut_obs();
    if (!r) check(name, model_out(t, o, rd));
    @(posedge clk);
    model_update(r, t, o, rd);
    #1;
  endtask

  typedef struct {
    logic [1:0] t;
    logic [4:0] o;
    logic       rd;
    obs_t       exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    int done_cnt;

    tbl[0]  = '{2'b00, 5'b10000, 1'b1, pack(1, 0, 2'b00, 5'b00000, 4'd0, 0, 0, 0)};
    tbl[1]  = '{2'b00, 5'b10000, 1'b1, pack(1, 1, 2'b01, 5'b00110, 4'd1, 1, 0, 0)};
    tbl[2]  = '{2'b00, 5'b10000, 1'b1, pack(1, 1, 2'b01, 5'b00110, 4'd2, 1, 0, 0)};
    tbl[3]  = '{2'b00, 5'b10000, 1'b1, pack(1, 1, 2'b01, 5'b00110, 4'd3, 1, 1, 0)};
    tbl[4]  = '{2'b01, 5'b10000, 1'b1, pack(0, 0, 2'b00, 5'b00000, 4'd0, 0, 0, 0)};
    tbl[5]  = '{2'b00, 5'b11000, 1'b1, pack(1, 0, 2'b00, 5'b00000, 4'd0, 0, 0, 0)};
    tbl[6]  = '{2'b00, 5'b11000, 1'b1, pack(1, 1, 2'b01, 5'b00111, 4'd1, 1, 0, 0)};
    tbl[7]  = '{2'b00, 5'b11000, 1'b0, pack(1, 0, 2'b01, 5'b00101, 4'd2, 1, 0, 0)};
    tbl[8]  = '{2'b00, 5'b11000, 1'b0, pack(1, 0, 2'b01, 5'b00101, 4'd2, 1, 0, 0)};
    tbl[9]  = '{2'b00, 5'b11000, 1'b1, pack(1, 1, 2'b01, 5'b00111, 4'd2, 1, 0, 0)};
    tbl[10] = '{2'b00, 5'b11000, 1'b1, pack(1, 1, 2'b01, 5'b00111, 4'd3, 1, 1, 0)};
    tbl[11] = '{2'b11, 5'b11111, 1'b0, pack(0, 0, 2'b00, 5'b00000, 4'd0, 0, 0, 0)};
    tbl[12] = '{2'b00, 5'b01111, 1'b1, pack(0, 0, 2'b00, 5'b00000, 4'd0, 0, 0, 0)};

    rst = 1'b1; itype = 2'b01; op = 5'd0; ready = 1'b0;
    step("rst", 1'b1, 2'b01, 5'd0, 1'b0);
    step("rst", 1'b1, 2'b01, 5'd0, 1'b0);

    rst = 1'b0; itype = 2'b01; op = 5'b10000; ready = 1'b1;
    @(negedge clk);
    check("reset_state", '0);
    @(posedge clk);
    model_update(1'b0, 2'b01, 5'b10000, 1'b1);
    #1;

    // Vector load, store with two not-ready cycles, then non-vector types.
    for (int i = 0; i < 13; i++) begin
      rst = 1'b0; itype = tbl[i].t; op = tbl[i].o; ready = tbl[i].rd;
      @(negedge clk);
      check($sformatf("table_row%0d", i), tbl[i].exp);
      @(posedge clk);
      model_update(1'b0, tbl[i].t, tbl[i].o, tbl[i].rd);
      #1;
    end

    // Back-to-back loads: second accepted right after done, 8 stall cycles total.
    stall_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step("b2b", 1'b0, 2'b00, 5'b10000, 1'b1);
      stall_cnt += int'(last_obs[15]);
      done_cnt  += int'(last_obs[1]);
    end
    step("b2b_tail", 1'b0, 2'b01, 5'b00000, 1'b1);
    stall_cnt += int'(last_obs[15]);
    check_int("b2b_stall_cycles", stall_cnt, 8);
    check_int("b2b_done_pulses", done_cnt, 2);

    // Reset while the beat at element 2 is pending.
    step("rstmid", 1'b0, 2'b00, 5'b10000, 1'b1);
    step("rstmid", 1'b0, 2'b00, 5'b10000, 1'b1);
    step("rstmid_rst", 1'b1, 2'b00, 5'b10000, 1'b1);
    rst = 1'b0; itype = 2'b10; op = 5'b00000; ready = 1'b1;
    @(negedge clk);
    check("post_rst_zero", '0);
    @(posedge clk);
    model_update(1'b0, 2'b10, 5'b00000, 1'b1);
    #1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step("post_rst", 1'b0, 2'b10, 5'b00000, 1'b1);
      done_cnt += int'(last_obs[1]);
    end
    check_int("post_rst_no_done", done_cnt, 0);

    // Memory held not-ready well past TIMEOUT.
    step("longhold", 1'b0, 2'b00, 5'b11000, 1'b0);
    for (int i = 0; i < TIMEOUT + 6; i++) step("longhold", 1'b0, 2'b00, 5'b11000, 1'b0);
    step("longhold_after", 1'b0, 2'b01, 5'b00000, 1'b0);
    check_int("longhold_error", int'(error), int'(TO_EN));
    check_int("longhold_busy", int'(busy), int'(!TO_EN));
    for (int i = 0; i < VLEN; i++) step("longhold_drain", 1'b0, 2'b01, 5'b00000, 1'b1);
    step("longhold_load", 1'b0, 2'b00, 5'b10000, 1'b1);
    for (int i = 0; i < VLEN; i++) step("longhold_load", 1'b0, 2'b01, 5'b00000, 1'b1);
    check_int("error_sticky", int'(error), int'(TO_EN));
    step("err_clear_rst", 1'b1, 2'b01, 5'b00000, 1'b1);
    step("err_cleared", 1'b0, 2'b01, 5'b00000, 1'b1);

    for (int i = 0; i < 800; i++) begin
      logic       r;
      logic [1:0] t;
      logic [4:0] o;
      logic       rd;
      r  = ($urandom_range(0, 99) == 0);
      t  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      o  = 5'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      step("random", r, t, o, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
